// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin sharing of one datapath among N start/finished sequencers
module dp_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic [N_CLIENTS-1:0] client_start,
  input  logic [N_CLIENTS*INSTRUCTION_WIDTH-1:0] client_instruction,
  output logic [N_CLIENTS-1:0] client_finished,
  output logic [RESULT_WIDTH-1:0] client_result,
  output logic dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  input  logic dp_finished,
  input  logic [RESULT_WIDTH-1:0] dp_result
);
  localparam int PW = $clog2(N_CLIENTS);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;
  state_t state, state_n;
  logic [N_CLIENTS-1:0] pending;
  logic [INSTRUCTION_WIDTH-1:0] req_instr [N_CLIENTS];
  logic [PW-1:0] rr_ptr, g, pick;
  logic [PW:0] idx;
  logic found;
  assign client_finished = ~pending;
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_CLIENTS)) idx = idx - (PW+1)'(N_CLIENTS);
      if (!found && pending[idx[PW-1:0]]) begin
        found = 1'b1;
        pick = idx[PW-1:0];
      end
    end
  end
  always_comb begin
    state_n = state == IDLE  ? (found ? ISSUE : IDLE) :
              state == ISSUE ? HOLD :
              state == HOLD  ? WAIT :
              (dp_finished ? IDLE : WAIT);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      g <= '0;
      dp_start <= 1'b0;
      dp_instruction <= '0;
      client_result <= '0;
    end else begin
      state <= state_n;
      dp_start <= state_n == ISSUE || state_n == HOLD;
      if (state == IDLE && found) begin
        g <= pick;
        dp_instruction <= req_instr[pick];
      end
      if (state == WAIT && dp_finished) begin
        client_result <= dp_result;
        pending[g] <= 1'b0;
        rr_ptr <= g == PW'(N_CLIENTS - 1) ? '0 : g + PW'(1);
      end
      // the client in service keeps pending set, so its held start is ignored
      for (int i = 0; i < N_CLIENTS; i++)
        if (client_start[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          req_instr[i] <= client_instruction[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
        end
    end
  end
endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_dp_arbiter;
  localparam int N = 4, W = 32, R = 32;
  logic clock = 0, reset = 1;
  logic [N-1:0] client_start = '0;
  logic [N*W-1:0] client_instruction = '0;
  logic [N-1:0] client_finished;
  logic [R-1:0] client_result;
  logic dp_start;
  logic [W-1:0] dp_instruction;
  logic dp_finished = 0;
  logic [R-1:0] dp_result = '0;
  dp_arbiter #(.N_CLIENTS(N), .INSTRUCTION_WIDTH(W), .RESULT_WIDTH(R)) dut (
    .clock(clock), .reset(reset), .client_start(client_start),
    .client_instruction(client_instruction), .client_finished(client_finished),
    .client_result(client_result), .dp_start(dp_start), .dp_instruction(dp_instruction),
    .dp_finished(dp_finished), .dp_result(dp_result)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // datapath stand-in: manual drive, or auto replies after a random latency and stays finished
  logic auto_dp = 0, man_fin = 0, af = 0;
  logic [R-1:0] man_res = '0;
  int lat = 1, lcnt = 0;
  always @(negedge clock) begin
    if (dp_start) begin
      lcnt = 0;
      lat = $urandom_range(1, 6);
      af = $urandom_range(0, 3) == 0;
    end else begin
      if (lcnt < lat) lcnt++;
      af = lcnt >= lat;
    end
    dp_finished = auto_dp ? af : man_fin;
    dp_result = auto_dp ? (dp_instruction ^ 32'h5A5A_0F0F) : man_res;
  end
  // reference model: a pending set, a pointer, and the age of the current grant in cycles
  bit m_pend [N];
  logic [W-1:0] m_instr [N];
  logic [W-1:0] m_dpi;
  logic [R-1:0] m_res;
  int m_ptr, m_g, m_age, idx;
  bit m_busy, fnd;
  logic [N-1:0] cap;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_busy = 0; m_age = 0; m_dpi = '0; m_res = '0;
    end else begin
      for (int i = 0; i < N; i++) cap[i] = client_start[i] && !m_pend[i];
      if (m_busy) begin
        if (m_age >= 3 && dp_finished) begin
          m_res = dp_result;
          m_pend[m_g] = 0;
          m_ptr = (m_g + 1) % N;
          m_busy = 0;
        end else if (m_age < 3) m_age++;
      end else begin
        fnd = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!fnd && m_pend[idx]) begin
            fnd = 1; m_g = idx; m_busy = 1; m_age = 1; m_dpi = m_instr[idx];
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (cap[i]) begin
          m_pend[i] = 1;
          m_instr[i] = client_instruction[i*W +: W];
        end
    end
  end
  logic [W-1:0] gq [$];
  bit prev_start = 0;
  task automatic tick();
    logic [N-1:0] ef;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) ef[i] = !m_pend[i];
    check("dp_start", 64'(dp_start), 64'(m_busy && m_age < 3));
    check("dp_instruction", 64'(dp_instruction), 64'(m_dpi));
    check("client_finished", 64'(client_finished), 64'(ef));
    check("client_result", 64'(client_result), 64'(m_res));
    if (dp_start && !prev_start) gq.push_back(dp_instruction);
    prev_start = dp_start;
  endtask
  task automatic do_reset();
    reset = 1;
    client_start = '0;
    tick();
    tick();
    reset = 0;
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (t < budget && !(client_finished == '1 && !dp_start)) begin
      tick();
      t++;
    end
    check(tag, 64'(client_finished == '1), 64'(1));
  endtask
  task automatic check_g(input string tag, input int n, input logic [W-1:0] exp);
    check(tag, 64'(n < gq.size() ? gq[n] : '1), 64'(exp));
  endtask
  function automatic void set_instr(input int i, input logic [W-1:0] v);
    client_instruction[i*W +: W] = v;
  endfunction
  int hold [N];
  initial begin
    do_reset();
    check("rst_finished", 64'(client_finished), 64'(4'hf));
    check("rst_result", 64'(client_result), 64'(0));
    check("rst_start", 64'(dp_start), 64'(0));
    // reset in WAIT, then a finish while idle must be ignored
    set_instr(0, 32'h11);
    client_start = 4'b0001;
    tick(); tick();
    client_start = '0;
    repeat (4) tick();
    do_reset();
    check("t1_start", 64'(dp_start), 64'(0));
    check("t1_finished", 64'(client_finished), 64'(4'hf));
    check("t1_result", 64'(client_result), 64'(0));
    man_fin = 1; man_res = 32'hDEAD;
    repeat (3) tick();
    check("t1_idle_fin", 64'(client_finished), 64'(4'hf));
    check("t1_idle_res", 64'(client_result), 64'(0));
    man_fin = 0;
    // single op with a 5 cycle datapath
    set_instr(1, 32'h0000_00A5);
    client_start = 4'b0010;
    tick();
    check("t2_busy", 64'(client_finished), 64'(4'b1101));
    tick();
    client_start = '0;
    check("t2_start1", 64'(dp_start), 64'(1));
    check("t2_instr", 64'(dp_instruction), 64'(32'hA5));
    tick();
    check("t2_start2", 64'(dp_start), 64'(1));
    tick();
    check("t2_start3", 64'(dp_start), 64'(0));
    tick(); tick();
    check("t2_wait", 64'(client_finished[1]), 64'(0));
    man_fin = 1; man_res = 32'h3C;
    tick();
    check("t2_done", 64'(client_finished[1]), 64'(1));
    check("t2_result", 64'(client_result), 64'(32'h3C));
    man_fin = 0;
    // fairness: 0,2,3 together, then 0 re-requests while 2 is served
    do_reset();
    gq.delete();
    auto_dp = 1;
    set_instr(0, 32'h100); set_instr(2, 32'h102); set_instr(3, 32'h103);
    client_start = 4'b1101;
    tick(); tick();
    client_start = '0;
    for (int t = 0; t < 50 && !client_finished[0]; t++) tick();
    check("t3_c0_done", 64'(client_finished[0]), 64'(1));
    set_instr(0, 32'h110);
    client_start = 4'b0001;
    tick(); tick();
    client_start = '0;
    wait_idle("t3_idle", 200);
    check("t3_count", 64'(gq.size()), 64'(4));
    check_g("t3_g0", 0, 32'h100);
    check_g("t3_g1", 1, 32'h102);
    check_g("t3_g2", 2, 32'h103);
    check_g("t3_g3", 3, 32'h110);
    // wrap: steer the pointer to 3, then 3 and 0 together, then 0 and 1 together
    gq.delete();
    set_instr(2, 32'h202);
    client_start = 4'b0100;
    tick(); tick();
    client_start = '0;
    wait_idle("t4_idle_a", 100);
    set_instr(3, 32'h303); set_instr(0, 32'h300);
    client_start = 4'b1001;
    tick(); tick();
    client_start = '0;
    wait_idle("t4_idle_b", 200);
    set_instr(0, 32'h400); set_instr(1, 32'h401);
    client_start = 4'b0011;
    tick(); tick();
    client_start = '0;
    wait_idle("t4_idle_c", 200);
    check("t4_count", 64'(gq.size()), 64'(5));
    check_g("t4_g0", 0, 32'h202);
    check_g("t4_g1", 1, 32'h303);
    check_g("t4_g2", 2, 32'h300);
    check_g("t4_g3", 3, 32'h401);
    check_g("t4_g4", 4, 32'h400);
    // capture of client 2 at the edge client 1 completes
    auto_dp = 0; man_fin = 0;
    set_instr(1, 32'h501);
    client_start = 4'b0010;
    tick(); tick();
    client_start = '0;
    tick(); tick();
    man_fin = 1; man_res = 32'h55;
    set_instr(2, 32'h500);
    client_start = 4'b0100;
    tick();
    check("t5_finished", 64'(client_finished), 64'(4'b1011));
    check("t5_result", 64'(client_result), 64'(32'h55));
    man_fin = 0;
    tick();
    client_start = '0;
    check("t5_grant", 64'(dp_start), 64'(1));
    check("t5_instr", 64'(dp_instruction), 64'(32'h500));
    auto_dp = 1;
    wait_idle("t5_idle", 100);
    // stale finish held high across idle, ISSUE and HOLD
    auto_dp = 0;
    do_reset();
    man_fin = 1; man_res = 32'h66;
    repeat (4) tick();
    check("t6_idle_fin", 64'(client_finished), 64'(4'hf));
    check("t6_idle_res", 64'(client_result), 64'(0));
    set_instr(3, 32'h600);
    client_start = 4'b1000;
    tick(); tick();
    client_start = '0;
    tick(); tick();
    check("t6_hold", 64'(client_finished[3]), 64'(0));
    check("t6_hold_res", 64'(client_result), 64'(0));
    tick();
    check("t6_done", 64'(client_finished[3]), 64'(1));
    check("t6_res", 64'(client_result), 64'(32'h66));
    man_fin = 0;
    // random traffic with occasional resets
    auto_dp = 1;
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (hold[i] > 0) hold[i]--;
        else begin
          client_start[i] = $urandom_range(0, 7) == 0;
          if (client_start[i]) begin
            hold[i] = $urandom_range(0, 2);
            set_instr(i, $urandom());
          end
        end
      reset = $urandom_range(0, 499) == 0;
      tick();
    end
    reset = 0;
    client_start = '0;
    wait_idle("rand_drain", 300);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
